// File: rtl/change_dispenser.sv
// change_dispenser: pays out change largest-coin-first from a finite inventory, one coin per hopper handshake
module change_dispenser #(
  parameter int INIT_CNT_5  = 20,
  parameter int INIT_CNT_10 = 20,
  parameter int INIT_CNT_20 = 20,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       change,
  input  logic             change_valid,
  input  logic             refill,
  input  logic             eject_ack,
  output logic             eject_valid,
  output logic [1:0]       eject_coin,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [7:0]       remaining,
  output logic [CNT_W-1:0] cnt_5,
  output logic [CNT_W-1:0] cnt_10,
  output logic [CNT_W-1:0] cnt_20,
  output logic [2:0]       state_out
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SELECT = 3'd1, WAIT_ACK = 3'd2, DONE = 3'd3, FAULT = 3'd4} state_t;
  state_t state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [1:0] coin_q, coin_d;
  logic [CNT_W-1:0] c5_q, c5_d, c10_q, c10_d, c20_q, c20_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0] coin_val;
  logic refill_ok;
  assign coin_val = coin_q == 2'b11 ? 8'd20 : coin_q == 2'b10 ? 8'd10 : 8'd5;
  assign refill_ok = refill && (state_q == IDLE || state_q == DONE || state_q == FAULT);
  // Next-state logic: coin selection, handshake bookkeeping, ack timeout and refill
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    tcnt_d  = tcnt_q;
    c5_d    = refill_ok ? CNT_W'(INIT_CNT_5)  : c5_q;
    c10_d   = refill_ok ? CNT_W'(INIT_CNT_10) : c10_q;
    c20_d   = refill_ok ? CNT_W'(INIT_CNT_20) : c20_q;
    case (state_q)
      IDLE: if (change_valid) begin
        rem_d   = change;
        state_d = change == 8'd0 ? DONE : (change % 8'd5) != 8'd0 ? FAULT : SELECT;
      end
      SELECT: begin
        tcnt_d = '0;
        if (rem_q == 8'd0) state_d = DONE;
        else if (rem_q >= 8'd20 && c20_q != '0) begin coin_d = 2'b11; state_d = WAIT_ACK; end
        else if (rem_q >= 8'd10 && c10_q != '0) begin coin_d = 2'b10; state_d = WAIT_ACK; end
        else if (rem_q >= 8'd5 && c5_q != '0) begin coin_d = 2'b01; state_d = WAIT_ACK; end
        else state_d = FAULT;
      end
      WAIT_ACK: begin
        if (eject_ack) begin
          rem_d   = rem_q - coin_val;
          c5_d    = coin_q == 2'b01 ? c5_q - 1'b1 : c5_q;
          c10_d   = coin_q == 2'b10 ? c10_q - 1'b1 : c10_q;
          c20_d   = coin_q == 2'b11 ? c20_q - 1'b1 : c20_q;
          tcnt_d  = '0;
          state_d = SELECT;
        end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) state_d = FAULT;
        else tcnt_d = tcnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = FAULT;
    endcase
  end
  // State and datapath registers; reset restores full inventory and aborts any payout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= '0;
      tcnt_q  <= '0;
      c5_q    <= CNT_W'(INIT_CNT_5);
      c10_q   <= CNT_W'(INIT_CNT_10);
      c20_q   <= CNT_W'(INIT_CNT_20);
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      tcnt_q  <= tcnt_d;
      c5_q    <= c5_d;
      c10_q   <= c10_d;
      c20_q   <= c20_d;
    end
  end
  assign eject_valid = state_q == WAIT_ACK;
  assign eject_coin  = eject_valid ? coin_q : 2'b00;
  assign busy        = state_q == SELECT || state_q == WAIT_ACK;
  assign done        = state_q == DONE;
  assign fault       = state_q == FAULT;
  assign remaining   = rem_q;
  assign cnt_5       = c5_q;
  assign cnt_10      = c10_q;
  assign cnt_20      = c20_q;
  assign state_out   = state_q;
endmodule
